pack_8_32: RTL

PACK_8_32 -- requirements
Module: pack_8_32

---
 rtl/pack_pkg.sv | 31 +++
 rtl/pack_byte_cnt.sv | 25 ++
 rtl/pack_8_32.sv | 91 +++++++++
 3 files changed

// File: rtl/pack_pkg.sv
// Shared types and constants for the byte-to-word packer.
// The optional PACK_PARITY_EN build adds a parity output to pack_8_32.
package pack_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int IDX_W          = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Position 0 starts a fresh word, so stale lower bytes are cleared.
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input logic [BYTE_W-1:0] b,
    input logic [IDX_W-1:0]  pos
  );
    logic [WORD_W-1:0] w;
    w = word;
    case (pos)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/pack_byte_cnt.sv
// Byte index within the word being assembled: load restarts at 1 (sof resync),
// increment on accept, clear on word transfer.
module pack_byte_cnt
  import pack_pkg::*;
(
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx
);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L)
      idx <= '0;
    else if (load)
      idx <= IDX_W'(1);
    else if (inc)
      idx <= idx + 1'b1;
    else if (clr)
      idx <= '0;
  end

endmodule

// File: rtl/pack_8_32.sv
// Packs a byte stream (MSB first) into 32-bit words with valid/ready on both sides.
// Define PACK_PARITY_EN to add a registered even-parity output for data_out.
module pack_8_32
  import pack_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              sof_in,
  input  logic              ready_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [WORD_W-1:0] data_out,
  output logic              err_out
`ifdef PACK_PARITY_EN
  ,
  output logic              parity_out
`endif
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  pos;
  logic              accept;
  logic              xfer;
  logic              restart;
  logic [WORD_W-1:0] word_nxt;

  assign ready_out = !((state == FULL) && !ready_in);
  assign accept    = valid_in && ready_out;
  assign xfer      = valid_out && ready_in;
  // sof inside a partial word throws the partial away and starts over at byte 0
  assign restart   = accept && sof_in && (state == COLLECT);
  assign pos       = restart ? '0 : idx;
  assign word_nxt  = insert_byte(data_out, data_in, pos);

  pack_byte_cnt u_byte_cnt (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .load    (restart),
    .inc     (accept),
    .clr     (xfer),
    .idx     (idx)
  );

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      data_out  <= '0;
    end else begin
      err_out <= restart;
      if (accept)
        data_out <= word_nxt;
      case (state)
        IDLE: begin
          if (accept)
            state <= COLLECT;
        end
        COLLECT: begin
          if (accept && !sof_in && (idx == IDX_W'(BYTES_PER_WORD - 1))) begin
            state     <= FULL;
            valid_out <= 1'b1;
          end
        end
        FULL: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state     <= accept ? COLLECT : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACK_PARITY_EN
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L)
      parity_out <= 1'b0;
    else if (accept)
      parity_out <= ^word_nxt;
  end
`endif

endmodule
